// File: rtl/alu_mem_seq_pkg.sv
// alu_mem_seq_pkg: shared types and encodings for the ALU/memory command sequencer.
//   state_t      sequencer FSM states
//   cmd_t        packed command word, layout {op, mem_op, addr, a, b}
//   *_LSB/*_W    cmd_data field offsets and widths
//   OP_*/MEM_*   op and mem_op encodings
package alu_mem_seq_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int CMD_W      = 28;
    localparam int OP_LSB     = 26;
    localparam int MEM_OP_LSB = 24;
    localparam int ADDR_LSB   = 16;
    localparam int A_LSB      = 8;
    localparam int B_LSB      = 0;
    localparam int OP_W       = 2;
    localparam int DATA_W     = 8;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;
    localparam logic [1:0] MEM_ALU = 2'b00;
    localparam logic [1:0] MEM_WR  = 2'b01;
    localparam logic [1:0] MEM_RD  = 2'b10;
    localparam logic [1:0] MEM_RSV = 2'b11;
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [OP_W-1:0]   mem_op;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;
endpackage

// File: rtl/seq_cmd_fifo.sv
// seq_cmd_fifo: DEPTH x W synchronous FIFO with combinational head output.
//   clk, rst (sync, active-low) | push, din: write when not full | pop: advance when not empty
//   dout: current head entry | full, empty: occupancy flags
module seq_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 28
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push_ok, pop_ok;
    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/alu_mem_cmd_sequencer.sv
// alu_mem_cmd_sequencer: queues commands and issues them one at a time to the ALU/memory unit.
//   clk, rst (sync, active-low)
//   cmd_valid/cmd_ready/cmd_data : command input {op, mem_op, addr, a, b}
//   start, op, mem_op, addr, in_a, in_b, write_data : unit issue port (operands held between issues)
//   result, error, done          : unit completion port
//   rsp_valid/rsp_ready, rsp_result, rsp_error, rsp_timeout : response port
//   Optional macro SEQ_STATS_EN adds stat_done / stat_err saturating counters of accepted responses.
module alu_mem_cmd_sequencer
    import alu_mem_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [27:0] cmd_data,
    output logic        start,
    output logic [1:0]  op,
    output logic [1:0]  mem_op,
    output logic [7:0]  addr,
    output logic [7:0]  in_a,
    output logic [7:0]  in_b,
    output logic [7:0]  write_data,
    input  logic [15:0] result,
    input  logic        error,
    input  logic        done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_error,
    output logic        rsp_timeout
`ifdef SEQ_STATS_EN
    ,
    output logic [15:0] stat_done,
    output logic [15:0] stat_err
`endif
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TIMEOUT[TW-1:0];
    state_t        state, state_nxt;
    cmd_t          head;
    logic          empty, full, pop;
    logic [TW-1:0] timer;
    logic          rsv;
    assign cmd_ready  = !full;
    assign write_data = in_b;
    assign rsv        = mem_op == MEM_RSV;
    seq_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .pop   (pop),
        .din   (cmd_data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        start     = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                pop       = !empty;
                state_nxt = empty ? IDLE : ISSUE;
            end
            ISSUE: begin
                start     = !rsv;
                state_nxt = rsv ? RESP : WAIT;
            end
            WAIT: state_nxt = (done || timer == TMAX) ? RESP : WAIT;
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = rsp_ready ? IDLE : RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // Operands load only on pop, so they hold through WAIT/RESP/IDLE.
    // done has priority over the watchdog when both land in the same WAIT cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            {op, mem_op, addr, in_a, in_b} <= '0;
            timer       <= '0;
            rsp_result  <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (pop) {op, mem_op, addr, in_a, in_b} <= head;
            if (state == ISSUE) begin
                timer <= TW'(1);
                if (rsv) {rsp_result, rsp_error, rsp_timeout} <= {16'h0, 1'b1, 1'b0};
            end
            if (state == WAIT) begin
                timer <= timer + 1'b1;
                if (done)               {rsp_result, rsp_error, rsp_timeout} <= {result, error, 1'b0};
                else if (timer == TMAX) {rsp_result, rsp_error, rsp_timeout} <= {16'h0, 1'b1, 1'b1};
            end
        end
    end
`ifdef SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_done <= '0;
            stat_err  <= '0;
        end else if (rsp_valid && rsp_ready) begin
            stat_done <= stat_done + 16'(stat_done != 16'hFFFF);
            stat_err  <= stat_err + 16'(rsp_error && stat_err != 16'hFFFF);
        end
    end
`endif
endmodule

// File: tb/tb_alu_mem_cmd_sequencer.sv
// tb_alu_mem_cmd_sequencer: randomized bench with a behavioural response model and a unit model.
module tb_alu_mem_cmd_sequencer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [27:0] cmd_data = '0;
    logic        start;
    logic [1:0]  op, mem_op;
    logic [7:0]  addr, in_a, in_b, write_data;
    logic [15:0] result = '0;
    logic        error = 1'b0;
    logic        done = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_error, rsp_timeout;
    alu_mem_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .start(start), .op(op), .mem_op(mem_op), .addr(addr), .in_a(in_a), .in_b(in_b),
        .write_data(write_data), .result(result), .error(error), .done(done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [15:0] res;
        logic        err;
        logic        to;
        logic        rsv;
        int          lat;
        logic [27:0] cmd;
    } exp_t;
    typedef struct {
        logic hold;
        int   lat;
    } unit_t;
    exp_t        exp_q[$];
    unit_t       unit_q[$];
    logic [7:0]  ref_mem[256];
    logic [7:0]  unit_mem[256];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_start = 0;
    int          nstart = 0;
    int          exp_starts = 0;
    logic        prev_start = 1'b0;
    logic        prev_valid = 1'b0;
    logic        hold_rsp = 1'b1;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [27:0] mk(int o, int mo, int ad, int a, int b);
        return {o[1:0], mo[1:0], ad[7:0], a[7:0], b[7:0]};
    endfunction
    // Expected response derived from the command meaning, not from the sequencer internals.
    function automatic exp_t model(logic [27:0] c, logic hold, int lat);
        exp_t e;
        int   o  = int'(c[27:26]);
        int   mo = int'(c[25:24]);
        int   ad = int'(c[23:16]);
        int   a  = int'(c[15:8]);
        int   b  = int'(c[7:0]);
        int   r  = 0;
        logic er = 1'b0;
        e.cmd = c;
        e.rsv = mo == 3;
        e.lat = hold ? TIMEOUT : lat;
        e.to  = 1'b0;
        if (mo == 3) begin
            e.res = 16'h0;
            e.err = 1'b1;
            return e;
        end
        if (mo == 1) ref_mem[ad] = c[7:0];
        else if (mo == 2) r = int'(ref_mem[ad]);
        else if (o == 0) r = a + b;
        else if (o == 1) r = a - b;
        else if (o == 2) r = a * b;
        else if (b == 0) begin
            r  = 'hFFFF;
            er = 1'b1;
        end else r = a / b;
        e.res = hold ? 16'h0 : r[15:0];
        e.err = hold ? 1'b1 : er;
        e.to  = hold;
        return e;
    endfunction
    // Unit model: sees start, applies memory effect, returns done after lat WAIT cycles unless withheld.
    initial begin
        unit_t       u;
        logic [15:0] r;
        logic        er;
        forever begin
            @(negedge clk);
            if (start) begin
                u  = unit_q.size() > 0 ? unit_q.pop_front() : '{1'b0, 1};
                er = 1'b0;
                r  = 16'h0;
                case (mem_op)
                    2'b01: unit_mem[addr] = write_data;
                    2'b10: r = {8'h0, unit_mem[addr]};
                    default: case (op)
                        2'b00: r = {8'h0, in_a} + {8'h0, in_b};
                        2'b01: r = {8'h0, in_a} - {8'h0, in_b};
                        2'b10: r = in_a * in_b;
                        default: begin
                            er = in_b == 0;
                            r  = er ? 16'hFFFF : {8'h0, in_a / in_b};
                        end
                    endcase
                endcase
                @(posedge clk);
                repeat (u.lat - 1) @(posedge clk);
                if (!u.hold) begin
                    #1;
                    done   = 1'b1;
                    result = r;
                    error  = er;
                    @(posedge clk);
                    #1;
                    done   = 1'b0;
                    result = 16'($urandom);
                    error  = 1'b0;
                end
            end
        end
    end
    initial begin
        forever begin
            @(posedge clk);
            #1 rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end
    always @(negedge clk) begin
        exp_t e;
        if (!rst) exp_starts = nstart;
        else begin
            if (start) begin
                check("start_one_cycle", prev_start, 0);
                if (exp_q.size() > 0) check("issue_operands", {op, mem_op, addr, in_a, in_b, write_data},
                                            {exp_q[0].cmd, exp_q[0].cmd[7:0]});
                last_start = cyc;
                nstart++;
            end
            if (rsp_valid && !prev_valid && exp_q.size() > 0) begin
                check("start_count", nstart, exp_starts + (exp_q[0].rsv ? 0 : 1));
                if (!exp_q[0].rsv) check("rsp_latency", cyc - last_start, exp_q[0].lat + 1);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("unexpected_rsp", rsp_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    if (!e.rsv) exp_starts++;
                    check("rsp_fields", {rsp_result, rsp_error, rsp_timeout}, {e.res, e.err, e.to});
                end
            end
        end
        prev_start = start;
        prev_valid = rsp_valid;
        cyc++;
    end
    task automatic push(input logic [27:0] c, input logic hold, input int lat);
        int n = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_data  = c;
        while (!cmd_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) check("push_timeout", cmd_ready, 1);
        exp_q.push_back(model(c, hold, lat));
        if (c[25:24] != 2'b11) unit_q.push_back('{hold, lat});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask
    initial begin
        logic seen;
        int   mo;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = 8'h0;
            unit_mem[i] = 8'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {start, op, mem_op, addr, in_a, in_b, write_data, rsp_valid,
                                rsp_result, rsp_error, rsp_timeout}, 0);
        check("reset_cmd_ready", cmd_ready, 1);
        rst = 1'b1;
        hold_rsp = 1'b0;
        push(mk(0, 1, 10, 0, 42), 0, 1);
        push(mk(0, 2, 10, 0, 0), 0, 2);
        push(mk(0, 0, 0, 15, 25), 0, 1);
        push(mk(2, 0, 0, 6, 7), 0, 3);
        push(mk(3, 0, 0, 40, 0), 0, 1);
        push(mk(3, 0, 0, 40, 8), 0, 1);
        push(mk(0, 0, 0, 1, 2), 1, 1);
        push(mk(0, 3, 5, 1, 2), 0, 1);
        push(mk(1, 0, 0, 9, 3), 0, TIMEOUT);
        drain();
        hold_rsp = 1'b1;
        for (int i = 0; i <= DEPTH; i++)
            push(mk($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 7),
                    $urandom_range(0, 255), $urandom_range(0, 255)), 0, $urandom_range(1, 4));
        repeat (2) @(posedge clk);
        #1 check("full_cmd_ready", cmd_ready, 0);
        hold_rsp = 1'b0;
        drain();
        for (int i = 0; i < 60; i++) begin
            mo = $urandom_range(0, 7);
            mo = mo > 3 ? 0 : mo;
            push(mk($urandom_range(0, 3), mo, $urandom_range(0, 7), $urandom_range(0, 255),
                    $urandom_range(0, 15)), $urandom_range(0, 7) == 0, $urandom_range(1, TIMEOUT));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();
        push(mk(0, 0, 0, 1, 1), 0, 10);
        push(mk(0, 0, 0, 2, 2), 0, 1);
        push(mk(0, 0, 0, 3, 3), 0, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_wait", {rsp_valid, cmd_ready, start}, 3'b010);
        rst = 1'b1;
        exp_q.delete();
        unit_q.delete();
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 seen = seen | rsp_valid | start;
        end
        check("late_done_ignored", seen, 0);
        push(mk(2, 0, 0, 12, 12), 0, 2);
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
